// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and the format encoding for the pipelined immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational format classification and sign-extended immediate extraction at XLEN width.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int HALF_BRANCH = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt,
    output logic            illegal
);

    logic [XLEN-1:0] i_ext, s_ext, b_ext, u_ext, j_ext;
    logic [XLEN-1:0] b_val, j_val;

    assign i_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign s_ext = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign b_ext = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_ext = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    if (XLEN == 64) begin : g_u64
        assign u_ext = {{32{instr[31]}}, instr[31:12], 12'b0};
    end else begin : g_u32
        assign u_ext = {instr[31:12], 12'b0};
    end

    // Halfword units let the legacy branch adder keep its own <<1.
    assign b_val = (HALF_BRANCH != 0) ? {b_ext[XLEN-1], b_ext[XLEN-1:1]} : b_ext;
    assign j_val = (HALF_BRANCH != 0) ? {j_ext[XLEN-1], j_ext[XLEN-1:1]} : j_ext;

    always_comb begin
        imm     = '0;
        fmt     = FMT_ILL;
        illegal = 1'b1;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                imm = i_ext; fmt = FMT_I; illegal = 1'b0;
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    imm = i_ext; fmt = FMT_I; illegal = 1'b0;
                end
            end
            OP_STORE:        begin imm = s_ext; fmt = FMT_S; illegal = 1'b0; end
            OP_BRANCH:       begin imm = b_val; fmt = FMT_B; illegal = 1'b0; end
            OP_LUI, OP_AUIPC: begin imm = u_ext; fmt = FMT_U; illegal = 1'b0; end
            OP_JAL:          begin imm = j_val; fmt = FMT_J; illegal = 1'b0; end
            OP_REG, OP_REG32: begin fmt = FMT_R; illegal = 1'b0; end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a valid/ready input and a DEPTH-entry result FIFO.
// Optional IMM_GEN_ILL_CNT_EN adds a saturating ill_count of illegal-opcode pushes.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 2,
    parameter int HALF_BRANCH = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`ifdef IMM_GEN_ILL_CNT_EN
    ,
    output logic [15:0]     ill_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [XLEN-1:0] dec_imm;
    fmt_t            dec_fmt;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN), .HALF_BRANCH(HALF_BRANCH)) u_dec (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    logic [XLEN-1:0] imm_mem [DEPTH];
    fmt_t            fmt_mem [DEPTH];
    logic            ill_mem [DEPTH];

    logic [PW:0]   count_reg;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic          push, pop;

    assign in_ready  = (count_reg < CNT_DEPTH);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            imm_mem[wr_ptr_reg] <= dec_imm;
            fmt_mem[wr_ptr_reg] <= dec_fmt;
            ill_mem[wr_ptr_reg] <= dec_illegal;
        end
    end

    assign out_imm     = out_valid ? imm_mem[rd_ptr_reg] : '0;
    assign out_fmt     = out_valid ? fmt_mem[rd_ptr_reg] : 3'd0;
    assign out_illegal = out_valid ? ill_mem[rd_ptr_reg] : 1'b0;

`ifdef IMM_GEN_ILL_CNT_EN
    // Survives flush so software can read a lifetime count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ill_count <= '0;
        else if (push && dec_illegal && (ill_count != 16'hFFFF))
            ill_count <= ill_count + 16'd1;
    end
`endif

endmodule
